equalizer_band_mixer: RTL and testbench

Successor to the equalizer's combinational band-sum stage. Takes NUMBER_OF_BANDS filtered band samples. Applies a runtime-programmable signed fixed-point gain per band, using one time-multiplexed multiply-accumulate. Produces a rounded, saturated mix with a valid strobe. Gains are double-buffered (shadow/active), so a mix never uses a mix of old and new gains.

---
 rtl/equalizer_band_mixer.sv | 125 ++++++++++++
 tb/tb_equalizer_band_mixer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/equalizer_band_mixer.sv
// equalizer_band_mixer: weights each band by a double-buffered signed gain with one shared MAC, then rounds and saturates the mix.
// Ports: clk, rst (async, active-low), clk_enable (global hold); sample_valid/bands_in (sample set in);
// gain_wr_en/gain_wr_addr/gain_wr_data (shadow gain write), gain_commit (shadow -> active), overrun_clr;
// busy, mix_out/mix_valid/sat_flag (result), overrun (sticky dropped-sample flag).
module equalizer_band_mixer #(
    parameter int NUMBER_OF_BANDS = 8,
    parameter int BAND_BITS       = 16,
    parameter int OUT_BITS        = 16,
    parameter int GAIN_BITS       = 8,
    parameter int GAIN_FRAC_BITS  = 4,
    parameter int ADDR_BITS       = $clog2(NUMBER_OF_BANDS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clk_enable,
    input  logic                                 sample_valid,
    input  logic [NUMBER_OF_BANDS*BAND_BITS-1:0] bands_in,
    input  logic                                 gain_wr_en,
    input  logic [ADDR_BITS-1:0]                 gain_wr_addr,
    input  logic [GAIN_BITS-1:0]                 gain_wr_data,
    input  logic                                 gain_commit,
    input  logic                                 overrun_clr,
    output logic                                 busy,
    output logic signed [OUT_BITS-1:0]           mix_out,
    output logic                                 mix_valid,
    output logic                                 sat_flag,
    output logic                                 overrun
);
    localparam int PW = BAND_BITS + GAIN_BITS;
    localparam int AW = PW + $clog2(NUMBER_OF_BANDS);
    localparam int IW = ADDR_BITS + 1;
    localparam logic signed [GAIN_BITS-1:0] UNITY = GAIN_BITS'(1 << GAIN_FRAC_BITS);
    localparam logic signed [AW-1:0] HALF = (GAIN_FRAC_BITS > 0) ? AW'(1 << (GAIN_FRAC_BITS - 1)) : '0;
    localparam logic signed [AW-1:0] OMAX = {{(AW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [AW-1:0] OMIN = {{(AW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

    state_t                      state;
    logic signed [BAND_BITS-1:0] band_q     [NUMBER_OF_BANDS];
    logic signed [GAIN_BITS-1:0] shadow     [NUMBER_OF_BANDS];
    logic signed [GAIN_BITS-1:0] shadow_nxt [NUMBER_OF_BANDS];
    logic signed [GAIN_BITS-1:0] active     [NUMBER_OF_BANDS];
    logic [IW-1:0]               idx;
    logic [ADDR_BITS-1:0]        sel;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_q;
    logic signed [AW-1:0]        acc;
    logic signed [AW-1:0]        rnd;
    logic                        hi;
    logic                        lo;
    logic                        commit_pending;

    // Shadow bank as it will be after this cycle's write, so a same-cycle commit sees the write.
    always_comb begin
        for (int k = 0; k < NUMBER_OF_BANDS; k++)
            shadow_nxt[k] = (gain_wr_en && gain_wr_addr == ADDR_BITS'(k)) ? gain_wr_data : shadow[k];
    end

    // Products are registered one cycle ahead of the accumulate, so ACCUM runs N+1 cycles
    // (idx == N only drains the last product) and the result appears N+2 cycles after the sample.
    assign sel  = (idx < IW'(NUMBER_OF_BANDS)) ? idx[ADDR_BITS-1:0] : '0;
    assign prod = PW'(band_q[sel]) * PW'(active[sel]);
    assign rnd  = (acc + HALF) >>> GAIN_FRAC_BITS;
    assign hi   = rnd > OMAX;
    assign lo   = rnd < OMIN;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            acc            <= '0;
            prod_q         <= '0;
            mix_out        <= '0;
            mix_valid      <= 1'b0;
            sat_flag       <= 1'b0;
            overrun        <= 1'b0;
            commit_pending <= 1'b0;
            for (int k = 0; k < NUMBER_OF_BANDS; k++) begin
                shadow[k] <= UNITY;
                active[k] <= UNITY;
                band_q[k] <= '0;
            end
        end else begin
            // Strobes are refreshed every clock so they last exactly one cycle even if clk_enable drops.
            mix_valid <= clk_enable && state == OUTPUT;
            sat_flag  <= clk_enable && state == OUTPUT && (hi || lo);
            if (clk_enable) begin
                for (int k = 0; k < NUMBER_OF_BANDS; k++)
                    shadow[k] <= shadow_nxt[k];
                overrun <= (sample_valid && state != IDLE) || (overrun && !overrun_clr);
                if (state == IDLE && (commit_pending || gain_commit)) begin
                    for (int k = 0; k < NUMBER_OF_BANDS; k++)
                        active[k] <= shadow_nxt[k];
                    commit_pending <= 1'b0;
                end else if (gain_commit) begin
                    commit_pending <= 1'b1;
                end
                case (state)
                    IDLE: if (sample_valid) begin
                        for (int k = 0; k < NUMBER_OF_BANDS; k++)
                            band_q[k] <= bands_in[k*BAND_BITS +: BAND_BITS];
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                    ACCUM: begin
                        prod_q <= prod;
                        if (idx != '0)
                            acc <= acc + AW'(prod_q);
                        idx <= idx + 1'b1;
                        if (idx == IW'(NUMBER_OF_BANDS))
                            state <= OUTPUT;
                    end
                    OUTPUT: begin
                        mix_out <= hi ? OMAX[OUT_BITS-1:0] : lo ? OMIN[OUT_BITS-1:0] : rnd[OUT_BITS-1:0];
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_equalizer_band_mixer.sv
// tb_equalizer_band_mixer: directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_equalizer_band_mixer;
    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clk_enable = 1'b1;
    logic                sample_valid = 1'b0;
    logic [127:0]        bands_in = '0;
    logic                gain_wr_en = 1'b0;
    logic [2:0]          gain_wr_addr = '0;
    logic [7:0]          gain_wr_data = '0;
    logic                gain_commit = 1'b0;
    logic                overrun_clr = 1'b0;
    logic                busy;
    logic signed [15:0]  mix_out;
    logic                mix_valid;
    logic                sat_flag;
    logic                overrun;

    typedef struct {int mix; int sat; int t0; int lat;} exp_t;
    exp_t         sb [$];
    exp_t         e;
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           bc;
    logic [127:0] b;

    equalizer_band_mixer dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .sample_valid(sample_valid),
        .bands_in(bands_in), .gain_wr_en(gain_wr_en), .gain_wr_addr(gain_wr_addr),
        .gain_wr_data(gain_wr_data), .gain_commit(gain_commit), .overrun_clr(overrun_clr),
        .busy(busy), .mix_out(mix_out), .mix_valid(mix_valid), .sat_flag(sat_flag), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic logic [127:0] all_bands(int v);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = 16'(v);
        return r;
    endfunction

    // Issues one sample and records what the monitor must later see; also releases any gain/clear strobes set by the caller.
    task automatic send(logic [127:0] bi, int mix, int sat, int lat);
        bands_in = bi;
        sample_valid = 1'b1;
        sb.push_back('{mix, sat, cyc, lat});
        @(negedge clk);
        sample_valid = 1'b0;
        gain_wr_en = 1'b0;
        gain_commit = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic wr(int a, int d, bit c);
        gain_wr_addr = 3'(a);
        gain_wr_data = 8'(d);
        gain_wr_en = 1'b1;
        gain_commit = c;
        @(negedge clk);
        gain_wr_en = 1'b0;
        gain_commit = 1'b0;
    endtask

    task automatic drain(int last);
        for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
        chk("drain_pending", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk("mix_out_hold", mix_out, last);
    endtask

    initial forever begin
        @(negedge clk);
        if (mix_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_mix_valid actual=%0d required=no_strobe", mix_out);
            end else begin
                e = sb.pop_front();
                chk("mix_out", mix_out, e.mix);
                chk("sat_flag", sat_flag, e.sat);
                chk("latency", cyc - e.t0 - 1, e.lat);
            end
        end else if (sat_flag) begin
            checks++;
            failures++;
            $display("FAIL sat_without_valid actual=1 required=0");
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mix_out", mix_out, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        @(negedge clk);

        send(all_bands(1000), 8000, 0, 10);
        bc = 0;
        for (int i = 0; i < 30 && busy; i++) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles", bc, 10);
        drain(8000);

        send(all_bands(20000), 32767, 1, 10);
        drain(32767);
        send(all_bands(-20000), -32768, 1, 10);
        drain(-32768);

        for (int k = 0; k < 8; k++) wr(k, k == 0 ? 32 : 0, k == 7);
        b = all_bands(500);
        b[15:0] = 16'd1234;
        send(b, 2468, 0, 10);
        drain(2468);
        wr(0, 8, 1'b1);
        b[15:0] = 16'd3;
        send(b, 2, 0, 10);
        drain(2);
        b[15:0] = 16'hFFFD;
        send(b, -1, 0, 10);
        drain(-1);

        for (int k = 0; k < 8; k++) wr(k, 16, k == 7);
        send(all_bands(100), 800, 0, 10);
        repeat (2) @(negedge clk);
        wr(0, 0, 1'b1);
        drain(800);
        send(all_bands(100), 700, 0, 10);
        drain(700);
        wr(1, 0, 1'b0);
        send(all_bands(100), 700, 0, 10);
        drain(700);
        gain_wr_addr = 3'd0;
        gain_wr_data = 8'd32;
        gain_wr_en = 1'b1;
        gain_commit = 1'b1;
        send(all_bands(100), 800, 0, 10);
        drain(800);

        for (int k = 0; k < 8; k++) wr(k, 16, k == 7);
        send(all_bands(1000), 8000, 0, 10);
        repeat (3) @(negedge clk);
        bands_in = all_bands(5);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("overrun_set", overrun, 1);
        drain(8000);
        chk("overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("overrun_clr", overrun, 0);
        send(all_bands(1000), 8000, 0, 10);
        @(negedge clk);
        sample_valid = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        overrun_clr = 1'b0;
        chk("overrun_set_wins", overrun, 1);
        drain(8000);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        send(all_bands(1000), 8000, 0, 15);
        repeat (2) @(negedge clk);
        clk_enable = 1'b0;
        repeat (5) @(negedge clk);
        clk_enable = 1'b1;
        drain(8000);

        wr(0, 0, 1'b1);
        bands_in = all_bands(1000);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_mix_out", mix_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        send(all_bands(1000), 8000, 0, 10);
        drain(8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
